// File: rtl/memctrl_line.sv
// Byte-serial RAM bus controller arbitrating an instruction line fetch port and a
// 1/2/4-byte data load/store port; data requests take priority over fetches.
module memctrl_line #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 4,
   parameter int CNT_W      = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    io_buffer_full,
   input  logic                    flush,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [ADDR_W-1:0]       mem_a,
   output logic                    mem_wr,
   input  logic                    if_req,
   input  logic [ADDR_W-1:0]       if_addr,
   output logic                    if_done,
   output logic [8*LINE_BYTES-1:0] if_line,
   input  logic                    dc_req,
   input  logic                    dc_we,
   input  logic [2:0]              dc_len,
   input  logic                    dc_sext,
   input  logic [ADDR_W-1:0]       dc_addr,
   input  logic [31:0]             dc_wdata,
   output logic                    dc_done,
   output logic [31:0]             dc_rdata
);

   typedef enum logic [2:0] {IDLE, IF_RD, DC_RD, DC_WR, DONE} state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n, len, len_n, prev;
   logic [ADDR_W-1:0]       base, base_n, mem_a_n, cur_a, prev_a;
   logic [8*LINE_BYTES-1:0] line_buf, line_buf_n, cap, if_line_n;
   logic                    reissue, reissue_n;
   logic [7:0]              mem_dout_n;
   logic                    mem_wr_n, if_done_n, dc_done_n;
   logic [31:0]             dc_rdata_n, load_val;
   logic                    io_block, io_block_prev;

   assign prev          = cnt - CNT_W'(1);
   assign cur_a         = base + ADDR_W'(cnt);
   assign prev_a        = base + ADDR_W'(prev);
   assign io_block      = (cur_a[17:16] == 2'b11) && io_buffer_full;
   assign io_block_prev = (prev_a[17:16] == 2'b11) && io_buffer_full;

   // cnt counts bytes already addressed, so the byte arriving now is cnt-1
   always_comb begin
      cap = line_buf;
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
         if (CNT_W'(i) == prev) cap[8*i +: 8] = mem_din;
      end
   end

   always_comb begin
      load_val = cap[31:0];
      if (len == CNT_W'(1))
         load_val = {{24{dc_sext & cap[7]}}, cap[7:0]};
      else if (len == CNT_W'(2))
         load_val = {{16{dc_sext & cap[15]}}, cap[15:0]};
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      len_n      = len;
      base_n     = base;
      line_buf_n = line_buf;
      reissue_n  = reissue;
      mem_a_n    = mem_a;
      mem_dout_n = mem_dout;
      mem_wr_n   = 1'b0;
      if_done_n  = 1'b0;
      dc_done_n  = 1'b0;
      if_line_n  = if_line;
      dc_rdata_n = dc_rdata;

      if (!rdy) begin
         // frozen: the byte on the bus must be presented again once rdy returns
         if_done_n = if_done;
         dc_done_n = dc_done;
         if ((state == IF_RD || state == DC_RD || state == DC_WR) && cnt != '0)
            reissue_n = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (dc_req) begin
                  base_n  = dc_addr;
                  cnt_n   = '0;
                  len_n   = (dc_len == 3'd1) ? CNT_W'(1) :
                            (dc_len == 3'd2) ? CNT_W'(2) : CNT_W'(4);
                  state_n = dc_we ? DC_WR : DC_RD;
               end else if (if_req && !flush) begin
                  base_n  = if_addr;
                  cnt_n   = '0;
                  len_n   = CNT_W'(LINE_BYTES);
                  state_n = IF_RD;
               end
            end
            IF_RD, DC_RD: begin
               if (state == IF_RD && flush) begin
                  state_n   = IDLE;
                  cnt_n     = '0;
                  reissue_n = 1'b0;
               end else if (reissue) begin
                  mem_a_n   = prev_a;
                  reissue_n = 1'b0;
               end else begin
                  if (cnt != '0) line_buf_n = cap;
                  if (cnt == len) begin
                     state_n = DONE;
                     cnt_n   = '0;
                     if (state == IF_RD) begin
                        if_done_n = 1'b1;
                        if_line_n = cap;
                     end else begin
                        dc_done_n  = 1'b1;
                        dc_rdata_n = load_val;
                     end
                  end else begin
                     mem_a_n = cur_a;
                     cnt_n   = cnt + CNT_W'(1);
                  end
               end
            end
            DC_WR: begin
               if (reissue) begin
                  if (!io_block_prev) begin
                     mem_a_n    = prev_a;
                     mem_dout_n = dc_wdata[{prev[1:0], 3'b000} +: 8];
                     mem_wr_n   = 1'b1;
                     reissue_n  = 1'b0;
                  end
               end else if (cnt == len) begin
                  dc_done_n = 1'b1;
                  state_n   = DONE;
                  cnt_n     = '0;
               end else if (!io_block) begin
                  mem_a_n    = cur_a;
                  mem_dout_n = dc_wdata[{cnt[1:0], 3'b000} +: 8];
                  mem_wr_n   = 1'b1;
                  cnt_n      = cnt + CNT_W'(1);
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         len      <= '0;
         base     <= '0;
         line_buf <= '0;
         reissue  <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
         if_done  <= 1'b0;
         dc_done  <= 1'b0;
         if_line  <= '0;
         dc_rdata <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         len      <= len_n;
         base     <= base_n;
         line_buf <= line_buf_n;
         reissue  <= reissue_n;
         mem_a    <= mem_a_n;
         mem_dout <= mem_dout_n;
         mem_wr   <= mem_wr_n;
         if_done  <= if_done_n;
         dc_done  <= dc_done_n;
         if_line  <= if_line_n;
         dc_rdata <= dc_rdata_n;
      end
   end

endmodule

// File: tb/tb_memctrl_line.sv
// Directed bench for memctrl_line: combinational-read RAM model, write log, and
// hand-computed data, latency and pulse expectations.
module tb_memctrl_line;
   localparam int AW = 32;
   localparam int LB = 4;

   logic            clk = 1'b0, rst = 1'b1, rdy = 1'b1, io_buffer_full = 1'b0, flush = 1'b0;
   logic [7:0]      mem_din, mem_dout;
   logic [AW-1:0]   mem_a;
   logic            mem_wr;
   logic            if_req = 1'b0;
   logic [AW-1:0]   if_addr = '0;
   logic            if_done;
   logic [8*LB-1:0] if_line;
   logic            dc_req = 1'b0, dc_we = 1'b0, dc_sext = 1'b0;
   logic [2:0]      dc_len = 3'd4;
   logic [AW-1:0]   dc_addr = '0;
   logic [31:0]     dc_wdata = '0;
   logic            dc_done;
   logic [31:0]     dc_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ram [0:1023];
   logic [31:0] wa [$];
   logic [7:0]  wd [$];

   always #5 clk = ~clk;

   assign mem_din = ram[mem_a[9:0]];

   always @(posedge clk) begin
      if (mem_wr) begin
         wa.push_back(mem_a);
         wd.push_back(mem_dout);
      end
   end

   memctrl_line #(.ADDR_W(AW), .LINE_BYTES(LB), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .flush(flush),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_line(if_line),
      .dc_req(dc_req), .dc_we(dc_we), .dc_len(dc_len), .dc_sext(dc_sext),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_done(dc_done), .dc_rdata(dc_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge with the request raised; next edge is acceptance (E0).
   task automatic wait_done(input bit want_if, output int lat);
      lat = 0;
      @(posedge clk);
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!(want_if ? if_done : dc_done) && lat < 40);
   endtask

   task automatic finish_dc(input string tag);
      dc_req = 1'b0;
      @(posedge clk); #1;
      check(tag, 64'(dc_done), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      int seen;
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
      ram[10'h010] = 8'h80;
      ram[10'h000] = 8'hA0; ram[10'h001] = 8'hB1; ram[10'h002] = 8'hC2; ram[10'h003] = 8'hD3;
      ram[10'h040] = 8'h5E; ram[10'h041] = 8'h6F; ram[10'h042] = 8'h70; ram[10'h043] = 8'h81;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {mem_a, mem_dout, mem_wr, if_done, dc_done}, 64'd0);
      check("rst_data", {if_line, dc_rdata}, 64'd0);
      rst = 1'b0;

      // word load
      dc_req = 1'b1; dc_we = 1'b0; dc_len = 3'd4; dc_sext = 1'b0; dc_addr = 32'h100;
      wait_done(1'b0, lat);
      check("ld4_lat", 64'(lat), 64'd5);
      check("ld4_data", 64'(dc_rdata), 64'h44332211);
      finish_dc("ld4_pulse");

      // signed and unsigned byte loads
      dc_req = 1'b1; dc_len = 3'd1; dc_sext = 1'b1; dc_addr = 32'h10;
      wait_done(1'b0, lat);
      check("ldb_lat", 64'(lat), 64'd2);
      check("ldb_sext", 64'(dc_rdata), 64'hFFFFFF80);
      finish_dc("ldb_pulse");
      dc_req = 1'b1; dc_sext = 1'b0;
      wait_done(1'b0, lat);
      check("ldb_zext", 64'(dc_rdata), 64'h00000080);
      finish_dc("ldbz_pulse");

      // halfword store
      wa.delete(); wd.delete();
      dc_req = 1'b1; dc_we = 1'b1; dc_len = 3'd2; dc_addr = 32'h200; dc_wdata = 32'hAABBCCDD;
      wait_done(1'b0, lat);
      check("sth_lat", 64'(lat), 64'd3);
      finish_dc("sth_pulse");
      check("sth_count", 64'(wa.size()), 64'd2);
      check("sth_w0", {wa[0], wd[0]}, {32'h200, 8'hDD});
      check("sth_w1", {wa[1], wd[1]}, {32'h201, 8'hCC});

      // simultaneous data load and fetch: data first, fetch after DONE
      dc_req = 1'b1; dc_we = 1'b0; dc_len = 3'd4; dc_addr = 32'h100;
      if_req = 1'b1; if_addr = 32'h0;
      wait_done(1'b0, lat);
      check("arb_dc_lat", 64'(lat), 64'd5);
      check("arb_dc_data", 64'(dc_rdata), 64'h44332211);
      dc_req = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!if_done && lat < 40);
      check("arb_if_gap", 64'(lat), 64'd7);
      check("arb_if_line", 64'(if_line), 64'hD3C2B1A0);
      if_req = 1'b0;
      @(posedge clk); #1;
      check("arb_if_pulse", 64'(if_done), 64'd0);
      @(posedge clk); #1;

      // flush while byte 2 of a fetch is on the bus
      if_req = 1'b1; if_addr = 32'h40;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check("fl_addr", 64'(mem_a), 64'h42);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; if_req = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (if_done) seen++;
      end
      check("fl_no_done", 64'(seen), 64'd0);
      check("fl_line_kept", 64'(if_line), 64'hD3C2B1A0);
      dc_req = 1'b1; dc_len = 3'd1; dc_addr = 32'h10;
      wait_done(1'b0, lat);
      check("fl_idle_lat", 64'(lat), 64'd2);
      finish_dc("fl_pulse");

      // IO store held off by a full buffer for three cycles
      wa.delete(); wd.delete();
      io_buffer_full = 1'b1;
      dc_req = 1'b1; dc_we = 1'b1; dc_len = 3'd1; dc_addr = 32'h30000; dc_wdata = 32'h0000005A;
      @(posedge clk);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_wr) seen++;
      end
      io_buffer_full = 1'b0;
      lat = 3;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!dc_done && lat < 40);
      check("io_held", 64'(seen), 64'd0);
      check("io_lat", 64'(lat), 64'd5);
      finish_dc("io_pulse");
      check("io_count", 64'(wa.size()), 64'd1);
      check("io_w0", {wa[0], wd[0]}, {32'h30000, 8'h5A});

      // rdy low for three cycles in the middle of a word load
      dc_req = 1'b1; dc_we = 1'b0; dc_len = 3'd4; dc_addr = 32'h100;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rdy_hold_a", 64'(mem_a), 64'h101);
      rdy = 1'b1;
      lat = 5;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!dc_done && lat < 40);
      check("rdy_lat", 64'(lat), 64'd9);
      check("rdy_data", 64'(dc_rdata), 64'h44332211);
      finish_dc("rdy_pulse");

      // reset in the middle of a word store
      wa.delete(); wd.delete();
      dc_req = 1'b1; dc_we = 1'b1; dc_len = 3'd4; dc_addr = 32'h300; dc_wdata = 32'h01020304;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mrst_ctrl", {mem_a, mem_dout, mem_wr, if_done, dc_done}, 64'd0);
      check("mrst_data", {if_line, dc_rdata}, 64'd0);
      rst = 1'b0; dc_req = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (mem_wr || dc_done) seen++;
      end
      check("mrst_quiet", 64'(seen), 64'd0);
      check("mrst_wcount", 64'(wa.size()), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
